// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Packs mnemonic-level instruction requests into 32-bit MIPS words using the
// core's opcode map, buffers them in a small FIFO and streams them out to
// instruction memory at consecutive word addresses.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   in_valid/in_ready request handshake (in_ready = FIFO not full)
//   in_kind           instruction kind (0 R .. 9 j, 10-15 illegal)
//   in_rs/rt/rd/shamt register and shift fields
//   in_funct          R-type function field
//   in_imm            I-type immediate
//   in_target         J-type target
//   load_base         load the address counter from base_addr
//   base_addr         start address for load_base
//   clear_err         clears the sticky illegal-kind flag
//   wr_valid/wr_ready instruction-memory write handshake
//   wr_addr/wr_data   address counter and FIFO head word
//   err_illegal       sticky: an illegal kind was accepted
//   words_written     completed write count, wraps at 2^16
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              clear_err,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err_illegal,
  output logic [15:0]       words_written
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [5:0]        w_opcode;
  logic              w_legal;
  logic [31:0]       w_word;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  logic [31:0]       r_mem [DEPTH];
  logic [PTR_W:0]    r_wrPtr;
  logic [PTR_W:0]    r_rdPtr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_errIllegal;
  logic [15:0]       r_wordsWritten;

  // Opcode lookup; kinds 10-15 have no encoding and are flagged illegal.
  always_comb begin
    w_opcode = 6'b000000;
    w_legal  = 1'b1;
    case (in_kind)
      4'd0:    w_opcode = 6'b000000;
      4'd1:    w_opcode = 6'b000001;
      4'd2:    w_opcode = 6'b000010;
      4'd3:    w_opcode = 6'b000011;
      4'd4:    w_opcode = 6'b000100;
      4'd5:    w_opcode = 6'b000111;
      4'd6:    w_opcode = 6'b001000;
      4'd7:    w_opcode = 6'b001001;
      4'd8:    w_opcode = 6'b001010;
      4'd9:    w_opcode = 6'b001111;
      default: w_legal  = 1'b0;
    endcase
  end

  // Field packing by format; fields a format does not use are dropped.
  always_comb begin
    w_word = 32'h0000_0000;
    if (in_kind == 4'd0) begin
      w_word = {w_opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
    end else if (in_kind == 4'd9) begin
      w_word = {w_opcode, in_target};
    end else begin
      w_word = {w_opcode, in_rs, in_rt, in_imm};
    end
  end

  // Pointers carry an extra wrap bit so equal low bits can mean full or empty.
  assign w_empty  = (r_wrPtr == r_rdPtr);
  assign w_full   = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                    (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);

  // in_ready looks only at the registered state, so a same-cycle pop cannot
  // re-open a full FIFO.
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign wr_valid = !w_empty;
  assign w_pop    = wr_valid && wr_ready;

  assign wr_data       = r_mem[r_rdPtr[PTR_W-1:0]];
  assign wr_addr       = r_addr;
  assign err_illegal   = r_errIllegal;
  assign words_written = r_wordsWritten;

  // Storage needs no reset: contents are only visible while wr_valid is set.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[PTR_W-1:0]] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
      end
    end
  end

  // A load on the same edge as a pop wins: the popped word used the old
  // address, and the next word goes to base_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (load_base) begin
      r_addr <= base_addr;
    end else if (w_pop) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wordsWritten <= 16'd0;
    end else if (w_pop) begin
      r_wordsWritten <= r_wordsWritten + 16'd1;
    end
  end

  // Set has priority over clear so an error on the clearing edge is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_errIllegal <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_errIllegal <= 1'b1;
    end else if (clear_err) begin
      r_errIllegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder. A default-width instance (ADDR_W=8) and
// a narrow instance (ADDR_W=4) share all inputs; the narrow one is used to
// observe address wrap. Writes are recorded by negedge monitors into queues
// and compared against hand-computed words and addresses.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        load_base;
  logic [7:0]  base_addr;
  logic [3:0]  baseAddr4;
  logic        clear_err;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err_illegal;
  logic [15:0] words_written;

  logic        inReady4;
  logic        wrValid4;
  logic [3:0]  wrAddr4;
  logic [31:0] wrData4;
  logic        errIllegal4;
  logic [15:0] wordsWritten4;

  int checks;
  int passes;
  int cyc;

  logic [31:0] capData[$];
  logic [7:0]  capAddr[$];
  int          capCyc[$];
  logic [3:0]  capAddr4[$];

  instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .load_base(load_base), .base_addr(base_addr),
    .clear_err(clear_err), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .err_illegal(err_illegal),
    .words_written(words_written)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReady4),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
    .in_target(in_target), .load_base(load_base), .base_addr(baseAddr4),
    .clear_err(clear_err), .wr_valid(wrValid4), .wr_ready(wr_ready),
    .wr_addr(wrAddr4), .wr_data(wrData4), .err_illegal(errIllegal4),
    .words_written(wordsWritten4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so a handshake seen at the
  // negedge is the one that completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      capData.push_back(wr_data);
      capAddr.push_back(wr_addr);
      capCyc.push_back(cyc);
    end
    if (rst_n && wrValid4 && wr_ready) begin
      capAddr4.push_back(wrAddr4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCaps();
    capData.delete();
    capAddr.delete();
    capCyc.delete();
    capAddr4.delete();
  endtask

  task automatic applyStimulus(input logic [3:0] kind, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [4:0] shamt, input logic [5:0] funct,
                               input logic [15:0] imm, input logic [25:0] target);
    in_kind   = kind;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = shamt;
    in_funct  = funct;
    in_imm    = imm;
    in_target = target;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (wr_valid || wrValid4); i++) step();
    checks++;
    if (wr_valid !== 1'b0) $display("[TB] FAIL drain_timeout: wr_valid=%b want 0", wr_valid);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_in_ready: got %b want 1", in_ready); else passes++;
    checks++; if (wr_valid !== 1'b0) $display("[TB] FAIL rst_wr_valid: got %b want 0", wr_valid); else passes++;
    checks++; if (wr_addr !== 8'd0) $display("[TB] FAIL rst_wr_addr: got %h want 00", wr_addr); else passes++;
    checks++; if (err_illegal !== 1'b0) $display("[TB] FAIL rst_err: got %b want 0", err_illegal); else passes++;
    checks++; if (words_written !== 16'd0) $display("[TB] FAIL rst_words: got %0d want 0", words_written); else passes++;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_addi();
    clearCaps();
    wr_ready  = 1'b1;
    load_base = 1'b1;
    base_addr = 8'd0;
    baseAddr4 = 4'd0;
    applyStimulus(4'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
    in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    load_base = 1'b0;
    checks++; if (wr_valid !== 1'b1) $display("[TB] FAIL addi_latency: wr_valid=%b want 1", wr_valid); else passes++;
    checks++; if (wr_data !== 32'h05280005) $display("[TB] FAIL addi_word: got %h want 05280005", wr_data); else passes++;
    checks++; if (wr_addr !== 8'd0) $display("[TB] FAIL addi_addr: got %h want 00", wr_addr); else passes++;
    step();
    checks++; if (words_written !== 16'd1) $display("[TB] FAIL addi_words: got %0d want 1", words_written); else passes++;
    checks++; if (capData.size() !== 1) $display("[TB] FAIL addi_count: got %0d writes want 1", capData.size()); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] expWord [4];
    expWord[0] = 32'h00221820;
    expWord[1] = 32'h1FA80004;
    expWord[2] = 32'h2485FFFF;
    expWord[3] = 32'h3C000010;
    clearCaps();
    wr_ready  = 1'b1;
    load_base = 1'b1;
    base_addr = 8'd0;
    in_valid  = 1'b1;
    applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD, 26'd0);
    step();
    load_base = 1'b0;
    applyStimulus(4'd5, 5'd29, 5'd8, 5'd17, 5'd3, 6'h3F, 16'h0004, 26'h3FFFFFF);
    step();
    applyStimulus(4'd7, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    step();
    applyStimulus(4'd9, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000010);
    step();
    in_valid = 1'b0;
    drain();
    checks++; if (capData.size() !== 4) $display("[TB] FAIL b2b_count: got %0d want 4", capData.size()); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (capData[i] !== expWord[i] || capAddr[i] !== 8'(i) || capCyc[i] !== capCyc[0] + i)
        $display("[TB] FAIL b2b_write%0d: got %h@%h cyc+%0d want %h@%h cyc+%0d",
                 i, capData[i], capAddr[i], capCyc[i] - capCyc[0], expWord[i], 8'(i), i);
      else passes++;
    end
    checks++; if (words_written !== 16'd5) $display("[TB] FAIL b2b_words: got %0d want 5", words_written); else passes++;
  endtask

  task automatic test_backpressure();
    logic [3:0]  kinds [5];
    logic [4:0]  rss [5];
    logic [4:0]  rts [5];
    logic [15:0] imms [5];
    logic [31:0] expWord [5];
    int accepted;
    logic rdy;
    kinds[0] = 4'd2; rss[0] = 5'd1;  rts[0] = 5'd2;  imms[0] = 16'h00FF; expWord[0] = 32'h082200FF;
    kinds[1] = 4'd3; rss[1] = 5'd3;  rts[1] = 5'd4;  imms[1] = 16'h1234; expWord[1] = 32'h0C641234;
    kinds[2] = 4'd4; rss[2] = 5'd5;  rts[2] = 5'd6;  imms[2] = 16'h8000; expWord[2] = 32'h10A68000;
    kinds[3] = 4'd6; rss[3] = 5'd29; rts[3] = 5'd31; imms[3] = 16'h0008; expWord[3] = 32'h23BF0008;
    kinds[4] = 4'd8; rss[4] = 5'd7;  rts[4] = 5'd0;  imms[4] = 16'hFFFE; expWord[4] = 32'h28E0FFFE;
    clearCaps();
    wr_ready  = 1'b0;
    load_base = 1'b1;
    base_addr = 8'd0;
    accepted  = 0;
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(kinds[accepted], rss[accepted], rts[accepted], 5'd31, 5'd21, 6'h2A, imms[accepted], 26'h155);
      rdy = in_ready;
      step();
      load_base = 1'b0;
      if (rdy) accepted++;
    end
    applyStimulus(kinds[4], rss[4], rts[4], 5'd31, 5'd21, 6'h2A, imms[4], 26'h155);
    checks++; if (accepted !== 4) $display("[TB] FAIL bp_accepted: got %0d want 4", accepted); else passes++;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_full: in_ready=%b want 0", in_ready); else passes++;
    checks++; if (wr_data !== expWord[0]) $display("[TB] FAIL bp_hold: got %h want %h", wr_data, expWord[0]); else passes++;
    wr_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_no_reopen: in_ready=%b want 0", in_ready); else passes++;
    step();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_reopen: in_ready=%b want 1", in_ready); else passes++;
    step();
    in_valid = 1'b0;
    drain();
    checks++; if (capData.size() !== 5) $display("[TB] FAIL bp_count: got %0d want 5", capData.size()); else passes++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (capData[i] !== expWord[i] || capAddr[i] !== 8'(i))
        $display("[TB] FAIL bp_write%0d: got %h@%h want %h@%h", i, capData[i], capAddr[i], expWord[i], 8'(i));
      else passes++;
    end
  endtask

  task automatic test_addr_wrap();
    clearCaps();
    wr_ready  = 1'b1;
    load_base = 1'b1;
    base_addr = 8'd14;
    baseAddr4 = 4'd14;
    in_valid  = 1'b1;
    applyStimulus(4'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0001, 26'd0);
    step();
    load_base = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    drain();
    checks++;
    if (capAddr4.size() !== 3 || capAddr4[0] !== 4'd14 || capAddr4[1] !== 4'd15 || capAddr4[2] !== 4'd0)
      $display("[TB] FAIL wrap_addr4: got n=%0d %h %h %h want n=3 e f 0",
               capAddr4.size(), capAddr4[0], capAddr4[1], capAddr4[2]);
    else passes++;
    checks++;
    if (capAddr.size() !== 3 || capAddr[2] !== 8'd16)
      $display("[TB] FAIL wrap_addr8: got n=%0d last %h want n=3 last 10", capAddr.size(), capAddr[2]);
    else passes++;
  endtask

  task automatic test_illegal();
    clearCaps();
    wr_ready = 1'b1;
    applyStimulus(4'd12, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1111, 26'h1111);
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL ill_ready: in_ready=%b want 1", in_ready); else passes++;
    step();
    in_valid = 1'b0;
    checks++; if (err_illegal !== 1'b1) $display("[TB] FAIL ill_set: got %b want 1", err_illegal); else passes++;
    step();
    step();
    checks++; if (capData.size() !== 0 || wr_valid !== 1'b0)
      $display("[TB] FAIL ill_nowrite: got %0d writes wr_valid=%b want 0 0", capData.size(), wr_valid);
    else passes++;
    applyStimulus(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0);
    in_valid  = 1'b1;
    clear_err = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (err_illegal !== 1'b1) $display("[TB] FAIL ill_set_wins: got %b want 1", err_illegal); else passes++;
    step();
    clear_err = 1'b0;
    checks++; if (err_illegal !== 1'b0) $display("[TB] FAIL ill_clear: got %b want 0", err_illegal); else passes++;
    checks++; if (words_written !== 16'd13) $display("[TB] FAIL ill_words: got %0d want 13", words_written); else passes++;
  endtask

  task automatic test_reset_mid();
    clearCaps();
    wr_ready = 1'b0;
    in_valid = 1'b1;
    applyStimulus(4'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0007, 26'd0);
    step();
    step();
    step();
    in_valid = 1'b0;
    checks++; if (wr_valid !== 1'b1) $display("[TB] FAIL rm_queued: wr_valid=%b want 1", wr_valid); else passes++;
    rst_n    = 1'b0;
    wr_ready = 1'b1;
    #1;
    checks++; if (wr_valid !== 1'b0) $display("[TB] FAIL rm_valid: got %b want 0", wr_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL rm_ready: got %b want 1", in_ready); else passes++;
    checks++; if (words_written !== 16'd0) $display("[TB] FAIL rm_words: got %0d want 0", words_written); else passes++;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++; if (capData.size() !== 0 || wr_valid !== 1'b0 || words_written !== 16'd0)
      $display("[TB] FAIL rm_nowrite: got %0d writes wr_valid=%b words=%0d want 0 0 0",
               capData.size(), wr_valid, words_written);
    else passes++;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    load_base = 1'b0;
    base_addr = 8'd0;
    baseAddr4 = 4'd0;
    clear_err = 1'b0;
    wr_ready  = 1'b0;
    applyStimulus(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_addr_wrap();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
